au_seq: RTL and testbench

Command sequencer that acts as the hardware initiator for the arithmetic unit (`au`). It accepts one operation at a time on a valid/ready command port and drives the AU's `start`/operand/select inputs. It then waits for `done`, bounded by a timeout, and returns the S9.14 sign-magnitude result with a tag on a valid/ready response port. It sits between the Kalman-filter datapath controller and `au`, replacing testbench-style direct driving of the AU.

---
 rtl/au_seq.sv | 163 ++++++++++++++++
 tb/tb_au_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_seq.sv
// au_seq: single-outstanding command sequencer for the arithmetic unit.
// Issues one start pulse per accepted command, waits for done (bounded), returns result + tag.
module au_seq #(
  parameter int unsigned W       = 24,
  parameter int unsigned FRAC    = 14,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned TAGW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [1:0]      cmd_ysel,
  input  logic [W-1:0]    cmd_r,
  input  logic [W-1:0]    cmd_s,
  input  logic [W-1:0]    cmd_imm,
  input  logic [TAGW-1:0] cmd_tag,
  output logic            au_start,
  output logic [1:0]      au_op_sel,
  output logic [1:0]      au_mul_y_sel,
  output logic [W-1:0]    au_R,
  output logic [W-1:0]    au_S,
  output logic [W-1:0]    au_Iimm,
  input  logic [W-1:0]    au_result,
  input  logic            au_done,
  input  logic            au_busy,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  // The result format must leave at least one integer bit beside the sign.
  if (FRAC >= W - 1) begin : g_frac_chk
    $error("au_seq: FRAC must be smaller than W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            au_start_q, au_start_d;
  logic [1:0]      op_q, op_d;
  logic [1:0]      ysel_q, ysel_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    imm_q, imm_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic            rsp_err_q, rsp_err_d;

  // Held low through reset so upstream never sees a handshake while the block is held.
  assign cmd_ready = rst_n && (state_q == S_IDLE) && !au_busy;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    au_start_d  = 1'b0;
    op_d        = op_q;
    ysel_d      = ysel_q;
    r_d         = r_q;
    s_d         = s_q;
    imm_d       = imm_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_op;
          ysel_d     = cmd_ysel;
          r_d        = cmd_r;
          s_d        = cmd_s;
          imm_d      = cmd_imm;
          rsp_tag_d  = cmd_tag;
          au_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // done beats the timeout when both land in the same cycle
        if (au_done) begin
          rsp_data_d  = (au_result[W-2:0] == '0) ? '0 : au_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      au_start_q  <= 1'b0;
      op_q        <= '0;
      ysel_q      <= '0;
      r_q         <= '0;
      s_q         <= '0;
      imm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      au_start_q  <= au_start_d;
      op_q        <= op_d;
      ysel_q      <= ysel_d;
      r_q         <= r_d;
      s_q         <= s_d;
      imm_q       <= imm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign au_start     = au_start_q;
  assign au_op_sel    = op_q;
  assign au_mul_y_sel = ysel_q;
  assign au_R         = r_q;
  assign au_S         = s_q;
  assign au_Iimm      = imm_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_au_seq.sv
// Bench for au_seq: behavioural AU model plus a sign-magnitude arithmetic reference,
// directed scenarios followed by randomized commands.
module tb_au_seq;

  localparam int unsigned W       = 24;
  localparam int unsigned FRAC    = 14;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned TAGW    = 4;
  localparam longint MAXMAG = (longint'(1) << (W - 1)) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cmd_valid, cmd_ready;
  logic [1:0]      cmd_op, cmd_ysel;
  logic [W-1:0]    cmd_r, cmd_s, cmd_imm;
  logic [TAGW-1:0] cmd_tag;
  logic            au_start;
  logic [1:0]      au_op_sel, au_mul_y_sel;
  logic [W-1:0]    au_R, au_S, au_Iimm;
  logic [W-1:0]    au_result;
  logic            au_done, au_busy;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  au_seq #(.W(W), .FRAC(FRAC), .TIMEOUT(TIMEOUT), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ysel(cmd_ysel),
    .cmd_r(cmd_r), .cmd_s(cmd_s), .cmd_imm(cmd_imm), .cmd_tag(cmd_tag),
    .au_start(au_start), .au_op_sel(au_op_sel), .au_mul_y_sel(au_mul_y_sel),
    .au_R(au_R), .au_S(au_S), .au_Iimm(au_Iimm),
    .au_result(au_result), .au_done(au_done), .au_busy(au_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // ---- sign-magnitude reference arithmetic ----
  function automatic longint sm2i(input logic [W-1:0] x);
    return x[W-1] ? -longint'(x[W-2:0]) : longint'(x[W-2:0]);
  endfunction

  function automatic logic [W-1:0] i2sm(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m > MAXMAG) m = MAXMAG;
    return {(v < 0) && (m != 0), m[W-2:0]};
  endfunction

  function automatic logic [W-1:0] au_fn(input logic [1:0] op, input logic [1:0] ysel,
                                         input logic [W-1:0] r, input logic [W-1:0] s,
                                         input logic [W-1:0] imm);
    longint a, b;
    a = sm2i(r);
    case (op)
      2'd0:    return i2sm(a + sm2i(s));
      2'd1:    return i2sm(a - sm2i(s));
      2'd2: begin
        b = (ysel == 2'd0) ? sm2i(s) : sm2i(imm);
        return i2sm((a * b) / (longint'(1) << FRAC));
      end
      default: return i2sm(a + sm2i(imm));
    endcase
  endfunction

  function automatic logic [W-1:0] norm(input logic [W-1:0] x);
    logic [W-1:0] z;
    z = '0;
    return (x[W-2:0] == z[W-2:0]) ? z : x;
  endfunction

  // ---- behavioural AU: done arrives au_lat cycles after start is sampled ----
  int           au_lat   = 1;
  bit           au_never = 1'b0;
  bit           ovr_en   = 1'b0;
  logic [W-1:0] ovr_val  = '0;
  logic         late_done = 1'b0;
  logic         mdl_done;
  logic [W-1:0] mdl_res;
  int           mdl_cnt;

  assign au_done   = mdl_done | late_done;
  assign au_result = mdl_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
      mdl_res  <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (au_start) begin
        mdl_res <= ovr_en ? ovr_val : au_fn(au_op_sel, au_mul_y_sel, au_R, au_S, au_Iimm);
        if (!au_never) begin
          if (au_lat <= 1) mdl_done <= 1'b1;
          else             mdl_cnt  <= au_lat - 1;
        end
      end else if (mdl_cnt > 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) mdl_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outs(input string t);
    chk({t, ":au_start"},  64'(au_start), 64'd0);
    chk({t, ":au_op"},     64'({au_op_sel, au_mul_y_sel}), 64'd0);
    chk({t, ":au_R"},      64'(au_R), 64'd0);
    chk({t, ":au_S"},      64'(au_S), 64'd0);
    chk({t, ":au_Iimm"},   64'(au_Iimm), 64'd0);
    chk({t, ":rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({t, ":rsp_data"},  64'(rsp_data), 64'd0);
    chk({t, ":rsp_tag"},   64'(rsp_tag), 64'd0);
    chk({t, ":rsp_err"},   64'(rsp_err), 64'd0);
    chk({t, ":cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  logic [W-1:0]    last_data;
  logic [TAGW-1:0] last_tag;
  logic            last_err;
  bit              late_in_resp = 1'b0;

  // Entered shortly after a rising edge; returns one cycle after the response handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] ysel, input logic [W-1:0] r,
                        input logic [W-1:0] s, input logic [W-1:0] imm,
                        input logic [TAGW-1:0] tag, input int lat, input bit never, input int hold);
    logic [W-1:0] exp_d;
    logic         exp_e;
    int           exp_lat, k, starts;
    au_lat   = lat;
    au_never = never;
    if (never) begin
      exp_d = '0; exp_e = 1'b1; exp_lat = int'(TIMEOUT) + 2;
    end else begin
      exp_d = norm(ovr_en ? ovr_val : au_fn(op, ysel, r, s, imm));
      exp_e = 1'b0; exp_lat = lat + 1;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_ysel = ysel;
    cmd_r = r; cmd_s = s; cmd_imm = imm; cmd_tag = tag;
    k = 0;
    while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_r = W'($urandom); cmd_s = W'($urandom); cmd_imm = W'($urandom);
    cmd_op = 2'($urandom); cmd_ysel = 2'($urandom); cmd_tag = TAGW'($urandom);
    chk("au_fields", 64'({au_op_sel, au_mul_y_sel}), 64'({op, ysel}));
    chk("au_R", 64'(au_R), 64'(r));
    starts = 0; k = 0;
    while (!rsp_valid && k < 200) begin
      if (au_start) starts++;
      @(posedge clk); #1; k++;
    end
    chk("latency", 64'(k), 64'(exp_lat));
    chk("start_pulses", 64'(starts), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(exp_d));
    chk("rsp_tag", 64'(rsp_tag), 64'(tag));
    chk("rsp_err", 64'(rsp_err), 64'(exp_e));
    chk("au_hold", 64'({au_S, au_Iimm}), 64'({s, imm}));
    last_data = rsp_data; last_tag = rsp_tag; last_err = rsp_err;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        late_done = late_in_resp;
        @(posedge clk); #1;
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_fields", 64'({rsp_data, rsp_tag, rsp_err}), 64'({exp_d, tag, exp_e}));
        chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      late_done = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_valid", 64'(rsp_valid), 64'd0);
    chk("post_ready", 64'(cmd_ready), 64'(!au_busy));
  endtask

  logic [1:0]      r_op, r_ysel;
  logic [W-1:0]    r_r, r_s, r_imm;
  logic [TAGW-1:0] r_tag;
  int              r_lat, r_hold, seen;

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_ysel = '0;
    cmd_r = '0; cmd_s = '0; cmd_imm = '0; cmd_tag = '0;
    au_busy = 1'b0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // 3 + (-2) = 1
    do_cmd(2'd0, 2'd0, 24'h00C000, 24'h808000, 24'h000000, 4'd5, 1, 1'b0, 0);
    chk("add_val", 64'({last_data, last_tag, last_err}), 64'({24'h004000, 4'd5, 1'b0}));

    // AU hands back negative zero
    ovr_en = 1'b1; ovr_val = 24'h800000;
    do_cmd(2'd2, 2'd0, 24'h808000, 24'h000000, 24'h000000, 4'd3, 1, 1'b0, 0);
    ovr_en = 1'b0;
    chk("negzero", 64'(last_data), 64'd0);

    // Timeout, with a stray done during RESP and again in IDLE
    late_in_resp = 1'b1;
    do_cmd(2'd3, 2'd0, 24'h004000, 24'h000000, 24'h004000, 4'd7, 4, 1'b1, 2);
    late_in_resp = 1'b0;
    chk("timeout_err", 64'({last_err, last_data}), 64'({1'b1, 24'h000000}));
    late_done = 1'b1;
    @(posedge clk); #1;
    late_done = 1'b0;
    @(posedge clk); #1;
    chk("late_done_idle", 64'({rsp_valid, au_start, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));

    // Backpressure then back-to-back SUB: 4 - 1 = 3
    do_cmd(2'd1, 2'd0, 24'h014000, 24'h80C000, 24'h000000, 4'd2, 1, 1'b0, 5);
    chk("bp_val", 64'(last_data), 64'h020000);
    do_cmd(2'd1, 2'd0, 24'h010000, 24'h004000, 24'h000000, 4'd9, 1, 1'b0, 0);
    chk("sub_val", 64'(last_data), 64'h00C000);

    // Busy gating
    au_busy = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_r = 24'h004000; cmd_s = 24'h004000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("busy_ready", 64'(cmd_ready), 64'd0);
      chk("busy_start", 64'(au_start), 64'd0);
    end
    au_busy = 1'b0;
    #1;
    chk("busy_fall_ready", 64'(cmd_ready), 64'd1);
    do_cmd(2'd0, 2'd0, 24'h004000, 24'h004000, 24'h000000, 4'd1, 1, 1'b0, 0);
    chk("busy_val", 64'(last_data), 64'h008000);

    // Reset mid-WAIT abandons the operation
    au_lat = 20; au_never = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_ysel = 2'd1;
    cmd_r = 24'h00C000; cmd_s = 24'h004000; cmd_imm = 24'h004000; cmd_tag = 4'hA;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || au_start) seen++;
    end
    chk("no_stale_rsp", 64'(seen), 64'd0);
    do_cmd(2'd3, 2'd0, 24'h00C000, 24'h000000, 24'h808000, 4'hB, 3, 1'b0, 1);
    chk("after_rst_val", 64'(last_data), 64'h004000);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_ysel = 2'($urandom_range(0, 3));
      r_r    = W'($urandom);
      r_s    = ($urandom_range(0, 7) == 0) ? r_r : W'($urandom);
      r_imm  = W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        r_r[W-2:12] = '0; r_s[W-2:12] = '0; r_imm[W-2:12] = '0;
      end
      r_tag  = TAGW'($urandom);
      r_lat  = (r_op == 2'd3) ? int'($urandom_range(2, 6)) : 1;
      r_hold = int'($urandom_range(0, 3));
      do_cmd(r_op, r_ysel, r_r, r_s, r_imm, r_tag, r_lat, 1'b0, r_hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
